// File: rtl/ahb_buf_slave.sv
// ahb_buf_slave: AHB-Lite slave buffer, word-addressed SRAM with byte lanes, programmable wait states and ERROR response
// Ports: hclk/hrst (asynchronous active-low) clock and reset;
//        hsel/haddr/htrans/hwrite/hsize/hburst/hwdata/hready AHB-Lite slave inputs;
//        hreadyout/hresp/hrdata slave response (hrdata held outside read data phases).
module ahb_buf_slave #(
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic              hclk,
   input  logic              hrst,
   input  logic              hsel,
   input  logic [31:0]       haddr,
   input  logic [1:0]        htrans,
   input  logic              hwrite,
   input  logic [2:0]        hsize,
   input  logic [2:0]        hburst,
   input  logic [DATA_W-1:0] hwdata,
   input  logic              hready,
   output logic              hreadyout,
   output logic              hresp,
   output logic [DATA_W-1:0] hrdata
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [AW-1:0]     idx_q, idx_d, rd_idx;
   logic              write_q, write_d;
   logic [3:0]        be_q, be_d, a_be;
   logic [DATA_W-1:0] hrdata_q, hrdata_d, rd_word;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              accept, legal, wr_en;
   logic              unused_ok;
   assign unused_ok = ^hburst;
   assign hreadyout = (state_q != S_WAIT) && (state_q != S_ERR1);
   assign hresp     = (state_q == S_ERR1) || (state_q == S_ERR2);
   assign hrdata    = hrdata_q;
   assign wr_en     = (state_q == S_DATA) && write_q;
   // hreadyout gates acceptance so nothing is taken while WAIT or ERR1 stalls the bus
   assign accept    = hreadyout && hsel && hready && htrans[1];
   assign legal     = (haddr < 32'(DEPTH * 4)) && (hsize <= 3'd2) &&
                      !(hsize == 3'd1 && haddr[0]) && !(hsize == 3'd2 && haddr[1:0] != 2'd0);
   assign a_be      = hsize == 3'd0 ? 4'b0001 << haddr[1:0] :
                      hsize == 3'd1 ? (haddr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   always_comb begin
      state_d = S_IDLE;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      write_d = write_q;
      be_d    = be_q;
      if (state_q == S_WAIT) begin
         state_d = cnt_q == 4'd1 ? S_DATA : S_WAIT;
         cnt_d   = cnt_q - 4'd1;
      end else if (state_q == S_ERR1) begin
         state_d = S_ERR2;
      end else if (accept) begin
         state_d = !legal ? S_ERR1 : (WAIT_STATES == 0 ? S_DATA : S_WAIT);
         cnt_d   = 4'(WAIT_STATES);
         idx_d   = haddr[AW+1:2];
         write_d = hwrite;
         be_d    = a_be;
      end
   end
   // Read data is registered on entry to DATA; a write committing at that same edge is bypassed in
   always_comb begin
      rd_idx  = accept ? haddr[AW+1:2] : idx_q;
      rd_word = mem[rd_idx];
      for (int n = 0; n < 4; n++)
         if (wr_en && idx_q == rd_idx && be_q[n]) rd_word[8*n +: 8] = hwdata[8*n +: 8];
      hrdata_d = (state_d == S_DATA && !write_d) ? rd_word : hrdata_q;
   end
   always_ff @(posedge hclk or negedge hrst) begin
      if (!hrst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         write_q  <= 1'b0;
         be_q     <= '0;
         hrdata_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         write_q  <= write_d;
         be_q     <= be_d;
         hrdata_q <= hrdata_d;
      end
   end
   // Memory is not reset; reset forces state_q to IDLE so wr_en drops and pending writes are lost
   always_ff @(posedge hclk) begin
      if (wr_en)
         for (int n = 0; n < 4; n++)
            if (be_q[n]) mem[idx_q][8*n +: 8] <= hwdata[8*n +: 8];
   end
endmodule

// File: tb/tb_ahb_buf_slave.sv
// tb_ahb_buf_slave: table-driven scoreboard bench for ahb_buf_slave at 0, 2 and 3 wait states
module tb_ahb_buf_slave;
   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
   } vec_t;
   logic             hclk, hrst, hwrite;
   logic [2:0]       hsel, hsize, hburst, hro, hrsp;
   logic [31:0]      haddr, hwdata;
   logic [1:0]       htrans;
   logic [2:0][31:0] hrd;
   vec_t             tbl[$];
   vec_t             sb[$];
   int               nvec, nbad;
   ahb_buf_slave #(.DATA_W(32), .DEPTH(1024), .WAIT_STATES(0)) u0 (
      .hclk(hclk), .hrst(hrst), .hsel(hsel[0]), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
      .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(hro[0]),
      .hreadyout(hro[0]), .hresp(hrsp[0]), .hrdata(hrd[0]));
   ahb_buf_slave #(.DATA_W(32), .DEPTH(1024), .WAIT_STATES(2)) u1 (
      .hclk(hclk), .hrst(hrst), .hsel(hsel[1]), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
      .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(hro[1]),
      .hreadyout(hro[1]), .hresp(hrsp[1]), .hrdata(hrd[1]));
   ahb_buf_slave #(.DATA_W(32), .DEPTH(1024), .WAIT_STATES(3)) u2 (
      .hclk(hclk), .hrst(hrst), .hsel(hsel[2]), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
      .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(hro[2]),
      .hreadyout(hro[2]), .hresp(hrsp[2]), .hrdata(hrd[2]));
   initial hclk = 1'b0;
   always #5 hclk = ~hclk;
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end, got timeout required completion");
      $fatal(1);
   end
   function automatic int ws(input int d);
      return d == 0 ? 0 : (d == 1 ? 2 : 3);
   endfunction
   function automatic vec_t mk(input logic wr, input logic [31:0] a, input logic [2:0] s,
                               input logic [31:0] wd, input logic [31:0] rd, input logic err);
      vec_t v;
      v.wr = wr; v.addr = a; v.size = s; v.wdata = wd; v.rdata = rd; v.err = err;
      return v;
   endfunction
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask
   // Pipelined master: address phase of tbl[i] overlaps data phase of the scoreboard head
   task automatic run(input int d);
      int   i, cyc, wc;
      vec_t e;
      i = 0; cyc = 0; wc = 0;
      sb.delete();
      while ((i < tbl.size() || sb.size() != 0) && cyc < 500) begin
         hsel = '0;
         if (i < tbl.size()) begin
            hsel[d] = 1'b1; htrans = 2'd2; hwrite = tbl[i].wr; haddr = tbl[i].addr; hsize = tbl[i].size;
         end else begin
            htrans = 2'd0;
         end
         hwdata = sb.size() != 0 ? sb[0].wdata : 32'd0;
         @(negedge hclk);
         if (sb.size() != 0 && !hro[d]) begin
            wc++;
            check($sformatf("u%0d wait_hresp@%h", d, sb[0].addr), 32'(hrsp[d]), 32'(sb[0].err));
         end
         if (hro[d]) begin
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check($sformatf("u%0d hresp@%h", d, e.addr), 32'(hrsp[d]), 32'(e.err));
               check($sformatf("u%0d waits@%h", d, e.addr), 32'(wc), e.err ? 32'd1 : 32'(ws(d)));
               if (!e.wr && !e.err) check($sformatf("u%0d hrdata@%h", d, e.addr), hrd[d], e.rdata);
               wc = 0;
            end
            if (i < tbl.size()) begin
               sb.push_back(tbl[i]);
               i++;
            end
         end
         @(posedge hclk); #1;
         cyc++;
      end
      if (cyc >= 500) begin
         nvec++; nbad++;
         $display("FAIL u%0d timeout: got %0d cycles required completion", d, cyc);
      end
      hsel = '0; htrans = 2'd0;
      tbl.delete();
   endtask
   initial begin
      nvec = 0; nbad = 0;
      hrst = 1'b0; hsel = '0; haddr = '0; htrans = 2'd0; hwrite = 1'b0;
      hsize = 3'd0; hburst = 3'd0; hwdata = '0;
      for (int c = 0; c < 3; c++) begin
         @(negedge hclk);
         for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_hreadyout u%0d", d), 32'(hro[d]), 32'd1);
            check($sformatf("rst_hrdata u%0d", d), hrd[d], 32'd0);
         end
      end
      @(posedge hclk); #1;
      hrst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge hclk);
         for (int d = 0; d < 3; d++) begin
            check($sformatf("idle_hreadyout u%0d", d), 32'(hro[d]), 32'd1);
            check($sformatf("idle_hresp u%0d", d), 32'(hrsp[d]), 32'd0);
            check($sformatf("idle_hrdata u%0d", d), hrd[d], 32'd0);
         end
      end
      @(posedge hclk); #1;
      tbl.push_back(mk(1, 32'h010, 3'd2, 32'hDEADBEEF, 32'h0, 0));
      tbl.push_back(mk(0, 32'h010, 3'd2, 32'h0, 32'hDEADBEEF, 0));
      tbl.push_back(mk(1, 32'h020, 3'd2, 32'h00000000, 32'h0, 0));
      tbl.push_back(mk(1, 32'h021, 3'd0, 32'h0000AA00, 32'h0, 0));
      tbl.push_back(mk(1, 32'h022, 3'd1, 32'h12340000, 32'h0, 0));
      tbl.push_back(mk(0, 32'h020, 3'd2, 32'h0, 32'h1234AA00, 0));
      tbl.push_back(mk(1, 32'h000, 3'd2, 32'h11223344, 32'h0, 0));
      tbl.push_back(mk(1, 32'h1000, 3'd2, 32'hFFFFFFFF, 32'h0, 1));
      tbl.push_back(mk(0, 32'h010, 3'd2, 32'h0, 32'hDEADBEEF, 0));
      tbl.push_back(mk(1, 32'h003, 3'd1, 32'hFFFFFFFF, 32'h0, 1));
      tbl.push_back(mk(0, 32'h000, 3'd2, 32'h0, 32'h11223344, 0));
      tbl.push_back(mk(0, 32'h040, 3'd3, 32'h0, 32'h0, 1));
      tbl.push_back(mk(1, 32'hFFC, 3'd2, 32'hA5A5A5A5, 32'h0, 0));
      tbl.push_back(mk(0, 32'hFFF, 3'd0, 32'h0, 32'hA5A5A5A5, 0));
      tbl.push_back(mk(1, 32'h002, 3'd2, 32'hFFFFFFFF, 32'h0, 1));
      tbl.push_back(mk(1, 32'h013, 3'd0, 32'h55000000, 32'h0, 0));
      tbl.push_back(mk(0, 32'h010, 3'd0, 32'h0, 32'h55ADBEEF, 0));
      tbl.push_back(mk(0, 32'h000, 3'd2, 32'h0, 32'h11223344, 0));
      run(0);
      for (int c = 0; c < 2; c++) begin
         @(negedge hclk);
         check("hold_hrdata u0", hrd[0], 32'h11223344);
      end
      @(posedge hclk); #1;
      tbl.push_back(mk(1, 32'h010, 3'd2, 32'hDEADBEEF, 32'h0, 0));
      tbl.push_back(mk(0, 32'h010, 3'd2, 32'h0, 32'hDEADBEEF, 0));
      tbl.push_back(mk(0, 32'h1000, 3'd2, 32'h0, 32'h0, 1));
      tbl.push_back(mk(1, 32'h014, 3'd2, 32'h01020304, 32'h0, 0));
      tbl.push_back(mk(0, 32'h016, 3'd1, 32'h0, 32'h01020304, 0));
      run(1);
      tbl.push_back(mk(1, 32'h040, 3'd2, 32'hCAFEF00D, 32'h0, 0));
      run(2);
      hsel[2] = 1'b1; htrans = 2'd2; hwrite = 1'b1; haddr = 32'h040; hsize = 3'd0;
      @(posedge hclk); #1;
      hsel = '0; htrans = 2'd0; hwdata = 32'h00000055;
      check("midrst_wait1 hreadyout", 32'(hro[2]), 32'd0);
      @(posedge hclk); #1;
      check("midrst_wait2 hreadyout", 32'(hro[2]), 32'd0);
      hrst = 1'b0;
      #1;
      check("midrst_async hreadyout", 32'(hro[2]), 32'd1);
      check("midrst_async hresp", 32'(hrsp[2]), 32'd0);
      check("midrst_async hrdata u0", hrd[0], 32'd0);
      @(posedge hclk);
      @(posedge hclk); #1;
      hrst = 1'b1;
      hwdata = '0;
      @(posedge hclk); #1;
      check("post_rst hreadyout u2", 32'(hro[2]), 32'd1);
      tbl.push_back(mk(0, 32'h040, 3'd2, 32'h0, 32'hCAFEF00D, 0));
      run(2);
      tbl.push_back(mk(0, 32'h010, 3'd2, 32'h0, 32'h55ADBEEF, 0));
      run(0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end
endmodule

// File: doc/ahb_buf_slave.md
Name: ahb_buf_slave

Overview:
- AHB-Lite slave buffer: word-addressed SRAM behind a single AHB-Lite slave port, with programmable wait states.
- Acts as the responder for the AHB master in the CNN subsystem. Holds input pixels and weights, and receives the 16-bit CNN results written back by the master.
- Supports byte, halfword and word transfers with little-endian lanes.
- Returns the two-cycle ERROR response for illegal accesses.

Parameters:
DATA_W, 32, bus data width; only 32 is supported.
DEPTH, 1024, number of 32-bit words; valid byte addresses are 0 to DEPTH*4-1.
WAIT_STATES, 0, wait cycles inserted in every OKAY data phase (0-15).

Ports:
hclk  in  1  bus clock; all state updates on the rising edge.
hrst  in  1  asynchronous, active-low reset.
hsel  in  1  slave select.
haddr  in  32  byte address.
htrans  in  2  0=IDLE, 1=BUSY, 2=NONSEQ, 3=SEQ.
hwrite  in  1  1=write, 0=read.
hsize  in  3  0=byte, 1=halfword, 2=word.
hburst  in  3  accepted and ignored; every beat is decoded independently.
hwdata  in  DATA_W  write data, valid in the data phase.
hready  in  1  global ready; qualifies the address phase.
hreadyout  out  1  slave ready, ends the data phase.
hresp  out  1  0=OKAY, 1=ERROR.
hrdata  out  DATA_W  read data, valid when hreadyout=1 for a read.

Behaviour:
- Reset (hrst=0, asynchronous):
  - hreadyout=1, hresp=0, hrdata=0, FSM returns to IDLE.
  - Any pending write is dropped; memory contents are not cleared.
- Address-phase accept: a transfer is accepted on a rising edge when hsel=1, hready=1 and htrans is NONSEQ or SEQ.
  - The accept latches addr, hwrite and hsize.
  - IDLE/BUSY, or hsel=0, accepts nothing; the next cycle gives a zero-wait OKAY.
- Legality check at accept. The access is illegal if any of these hold:
  - haddr >= DEPTH*4
  - hsize > 2
  - hsize=1 with haddr[0]=1
  - hsize=2 with haddr[1:0]!=0
- FSM states:
  - IDLE: hreadyout=1, hresp=0.
    - A legal accept with WAIT_STATES=0 goes to DATA.
    - A legal accept with WAIT_STATES>0 goes to WAIT, with the counter loaded to WAIT_STATES.
    - An illegal accept goes to ERR1.
  - WAIT: hreadyout=0, hresp=0. The counter decrements every cycle; on reaching 1 the FSM goes to DATA.
  - DATA: hreadyout=1, hresp=0.
    - Reads: hrdata holds the addressed word (full 32 bits regardless of hsize).
    - Writes: hwdata is committed at the end of this cycle, on the active lanes only.
    - A new accept in the same cycle (pipelined) routes exactly as from IDLE; otherwise the FSM goes to IDLE.
  - ERR1: hreadyout=0, hresp=1; always goes to ERR2. No memory write occurs.
  - ERR2: hreadyout=1, hresp=1. An accept in this cycle is decoded normally.
- Byte lanes:
  - byte: lane haddr[1:0].
  - halfword: lanes {haddr[1],0} and {haddr[1],1}.
  - word: all four lanes.
  - Lane n maps to bits [8n+7:8n].
- Latency: every legal transfer occupies WAIT_STATES+1 data-phase cycles. With WAIT_STATES=0, back-to-back transfers run at one per cycle.
- Read-after-write hazard: a read whose data phase immediately follows a write to the same word must return the merged new value. Bypass the write lanes into hrdata.
- hrdata holds its last value whenever the output is not a read DATA cycle.
- A hsel or htrans change during WAIT or ERR1 is ignored: hready is low, so nothing is accepted.
- Reset asserted mid-WAIT: the transfer is aborted with no memory write; after release the slave is in IDLE with hreadyout=1.

Test Plan:
- Reset then idle: hrst=0 for 3 cycles, release, htrans=IDLE -> hreadyout=1, hresp=0, hrdata=0 every cycle.
- Word write/read, WAIT_STATES=0: write 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> read data phase is the next cycle, hrdata=0xDEADBEEF, hreadyout never low.
- Sub-word writes: word 0 at 0x20, then byte 0xAA to 0x21 (hwdata=0x0000AA00), then halfword 0x1234 to 0x22 (hwdata=0x12340000) -> read 0x20 returns 0x1234AA00.
- Wait states, WAIT_STATES=2: read 0x10 -> hreadyout=0 for 2 cycles, then 1 with hrdata=0xDEADBEEF.
- Errors: word access at 0x1000 (DEPTH=1024), or halfword at 0x03 -> hreadyout 0 then 1, hresp=1 in both cycles, memory unchanged; a NONSEQ read in ERR2 completes with OKAY.
- Reset mid-transfer, WAIT_STATES=3: write 0x55 to 0x40, assert hrst during the 2nd wait cycle -> hreadyout=1 immediately; after release, a read of 0x40 returns the prior contents.
